// File: rtl/clk_div_32m768.sv
// clk_div_32m768: binary clock divider producing 15 phase-aligned clocks and rising-edge strobes
module clk_div_32m768 (
  input  logic        clk32M768,
  input  logic        rst_32M768,
  output logic        clk16M384,
  output logic        clk8M192,
  output logic        clk4M096,
  output logic        clk2M048,
  output logic        clk1M024,
  output logic        clk512K,
  output logic        clk256K,
  output logic        clk128K,
  output logic        clk64K,
  output logic        clk32K,
  output logic        clk16K,
  output logic        clk8K,
  output logic        clk4K,
  output logic        clk2K,
  output logic        clk1K,
  output logic [14:0] ce_rise
);
  logic [14:0] cnt;
  logic [14:0] ce_next;
  // strobe k fires next cycle when the low k+1 counter bits are about to reach zero
  always_comb
    for (int i = 0; i < 15; i++)
      ce_next[i] = (cnt & 15'((16'd2 << i) - 16'd1)) == 15'd1;
  always_ff @(posedge clk32M768 or posedge rst_32M768)
    if (rst_32M768) begin
      cnt     <= '0;
      ce_rise <= '1;
    end else begin
      cnt     <= cnt - 15'd1;
      ce_rise <= ce_next;
    end
  assign {clk1K, clk2K, clk4K, clk8K, clk16K, clk32K, clk64K, clk128K,
          clk256K, clk512K, clk1M024, clk2M048, clk4M096, clk8M192, clk16M384} = cnt;
endmodule

// File: tb/tb_clk_div_32m768.sv
// tb_clk_div_32m768: randomized reset/run checks of the divider against a cycle-count model
module tb_clk_div_32m768;
  logic clk = 0;
  logic rst = 1;
  logic clk16M384, clk8M192, clk4M096, clk2M048, clk1M024, clk512K, clk256K, clk128K;
  logic clk64K, clk32K, clk16K, clk8K, clk4K, clk2K, clk1K;
  logic [14:0] ce_rise;
  logic [14:0] clks;
  int vectors = 0;
  int miscompares = 0;
  longint n = 0;

  clk_div_32m768 dut (
    .clk32M768(clk), .rst_32M768(rst),
    .clk16M384(clk16M384), .clk8M192(clk8M192), .clk4M096(clk4M096), .clk2M048(clk2M048),
    .clk1M024(clk1M024), .clk512K(clk512K), .clk256K(clk256K), .clk128K(clk128K),
    .clk64K(clk64K), .clk32K(clk32K), .clk16K(clk16K), .clk8K(clk8K), .clk4K(clk4K),
    .clk2K(clk2K), .clk1K(clk1K), .ce_rise(ce_rise)
  );

  assign clks = {clk1K, clk2K, clk4K, clk8K, clk16K, clk32K, clk64K, clk128K,
                 clk256K, clk512K, clk1M024, clk2M048, clk4M096, clk8M192, clk16M384};

  always #15 clk = ~clk;

  // n = master edges since reset release; clock k is high for the first 2^k cycles of each period
  function automatic logic [14:0] exp_clk(longint c);
    logic [14:0] r = '0;
    for (int k = 0; k < 15; k++)
      r[k] = (c > 0) && (((c - 1) % (longint'(1) << (k + 1))) < (longint'(1) << k));
    return r;
  endfunction

  function automatic logic [14:0] exp_ce(longint c);
    logic [14:0] r = '0;
    for (int k = 0; k < 15; k++)
      r[k] = (c % (longint'(1) << (k + 1))) == 0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_clk"}, 32'(clks), 32'(exp_clk(n)));
    check({tag, "_ce"}, 32'(ce_rise), 32'(exp_ce(n)));
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all("run");
    end
  endtask

  task automatic async_reset(input int hold);
    @(posedge clk);
    #5 rst = 1;
    n = 0;
    #1;
    check("async_clk", 32'(clks), 32'h0);
    check("async_ce", 32'(ce_rise), 32'h7FFF);
    repeat (hold) begin
      @(negedge clk);
      check_all("hold");
    end
    rst = 0;
  endtask

  initial begin
    repeat (9) begin
      @(negedge clk);
      check_all("reset");
    end
    rst = 0;
    run(2);
    run(65534);
    async_reset(2);
    run(1);
    async_reset(1);
    for (int s = 0; s < 5; s++) begin
      run($urandom_range(1, 4000));
      check("pre_rst_clk1K", 32'(clk1K), 32'(exp_clk(n) >> 14));
      async_reset($urandom_range(1, 5));
    end
    run(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
